vblank_sequencer: RTL and testbench

- Sequences per-frame game-state updates (input sample, physics, obstacle scroll, collision) during vertical blanking, so game logic never changes mid-scan.
- Watches the sync generator's hpos/vpos and starts a sequence at the first blank line.
- Steps through N_STAGES update units with a req/done handshake, one stage at a time.
- Flags an overrun if the sequence has not finished before active video resumes.

---
 rtl/vga_timing_pkg.sv | 15 +
 rtl/vblank_event_detect.sv | 16 +
 rtl/vblank_sequencer.sv | 164 ++++++++++++++++
 tb/tb_vblank_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Frame timing constants shared with the sync generator, plus the sequencer state type.
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_MAX     = 799;
  localparam int V_DISPLAY = 480;
  localparam int V_MAX     = 524;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/vblank_event_detect.sv
// Decodes the first and last cycles of vertical blanking from the beam position.
module vblank_event_detect #(
  parameter int V_DISPLAY = 480,
  parameter int V_MAX     = 524,
  parameter int H_MAX     = 799
) (
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  output logic       o_vb_start,
  output logic       o_vb_end
);

  assign o_vb_start = (i_vpos == 10'(V_DISPLAY)) && (i_hpos == 10'd0);
  assign o_vb_end   = (i_vpos == 10'(V_MAX))     && (i_hpos == 10'(H_MAX));

endmodule

// File: rtl/vblank_sequencer.sv
// Runs the per-frame update stages one at a time during vertical blanking.
// Optional frame divider enabled with `define FRAME_DIV_EN.
module vblank_sequencer #(
  parameter int N_STAGES  = 4,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_MAX     = vga_timing_pkg::V_MAX,
  parameter int H_MAX     = vga_timing_pkg::H_MAX,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          hpos,
  input  logic [9:0]          vpos,
  input  logic                pause,
  input  logic [N_STAGES-1:0] stage_done,
  input  logic                clear_overrun,
`ifdef FRAME_DIV_EN
  input  logic [1:0]          frame_div,
`endif
  output logic [N_STAGES-1:0] stage_req,
  output logic                busy,
  output logic                frame_tick,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic                overrun
);

  import vga_timing_pkg::*;

  localparam int IDX_W = $clog2(N_STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

  seq_state_t          r_state, w_state_next;
  logic [IDX_W-1:0]    r_idx, w_idx_next;
  logic [N_STAGES-1:0] r_req, w_req_next;
  logic                r_busy, w_busy_next;
  logic                r_tick, w_tick_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic                r_overrun, w_overrun_next;
  logic                w_vb_start, w_vb_end;
  logic                w_done_act;
  logic                w_start;
  logic [N_STAGES-1:0] w_onehot;
`ifdef FRAME_DIV_EN
  logic [1:0]          r_skip, w_skip_next;
`endif

  vblank_event_detect #(
    .V_DISPLAY (V_DISPLAY),
    .V_MAX     (V_MAX),
    .H_MAX     (H_MAX)
  ) u_event_detect (
    .i_hpos     (hpos),
    .i_vpos     (vpos),
    .o_vb_start (w_vb_start),
    .o_vb_end   (w_vb_end)
  );

  assign w_done_act = stage_done[r_idx];
  assign w_onehot   = {{(N_STAGES-1){1'b0}}, 1'b1} << r_idx;

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_req_next     = '0;
    w_tick_next    = 1'b0;
    w_cnt_next     = r_cnt;
    w_overrun_next = r_overrun & ~clear_overrun;
    w_start        = 1'b0;
`ifdef FRAME_DIV_EN
    w_skip_next    = r_skip;
`endif

    case (r_state)
      IDLE: begin
        if (w_vb_start && !pause) begin
`ifdef FRAME_DIV_EN
          // A skip count left above a lowered divider restarts the count without a sequence.
          if (r_skip == frame_div) begin
            w_start     = 1'b1;
            w_skip_next = 2'd0;
          end else if (r_skip > frame_div) begin
            w_skip_next = 2'd0;
          end else begin
            w_skip_next = r_skip + 2'd1;
          end
`else
          w_start = 1'b1;
`endif
        end
        if (w_start) begin
          w_state_next = RUN;
          w_idx_next   = '0;
          w_req_next   = {{(N_STAGES-1){1'b0}}, 1'b1};
          w_tick_next  = 1'b1;
          w_cnt_next   = r_cnt + 1'b1;
        end
      end

      RUN: begin
        // Completion of the final stage beats an abort landing on the same cycle.
        if (w_done_act && (r_idx == LAST_IDX)) begin
          w_state_next = IDLE;
        end else if (w_vb_end) begin
          w_state_next   = IDLE;
          w_overrun_next = 1'b1;
        end else if (w_done_act) begin
          w_idx_next   = r_idx + 1'b1;
          w_state_next = GAP;
        end else begin
          w_req_next = w_onehot;
        end
      end

      GAP: begin
        if (w_vb_end) begin
          w_state_next   = IDLE;
          w_overrun_next = 1'b1;
        end else begin
          w_state_next = RUN;
          w_req_next   = w_onehot;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_busy_next = (w_state_next != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_req     <= '0;
      r_busy    <= 1'b0;
      r_tick    <= 1'b0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
`ifdef FRAME_DIV_EN
      r_skip    <= 2'd0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_req     <= w_req_next;
      r_busy    <= w_busy_next;
      r_tick    <= w_tick_next;
      r_cnt     <= w_cnt_next;
      r_overrun <= w_overrun_next;
`ifdef FRAME_DIV_EN
      r_skip    <= w_skip_next;
`endif
    end
  end

  assign stage_req  = r_req;
  assign busy       = r_busy;
  assign frame_tick = r_tick;
  assign frame_cnt  = r_cnt;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_vblank_sequencer.sv
// Directed bench for vblank_sequencer: reset, full frame, abort, completion race, pause, divider, wrap.
module tb_vblank_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  hpos = '0;
  logic [9:0]  vpos = '0;
  logic        pause = 1'b0;
  logic [3:0]  stage_done = '0;
  logic        clear_overrun = 1'b0;
`ifdef FRAME_DIV_EN
  logic [1:0]  frame_div = 2'd0;
`endif
  logic [3:0]  stage_req;
  logic        busy;
  logic        frame_tick;
  logic [15:0] frame_cnt;
  logic        overrun;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  vblank_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .hpos          (hpos),
    .vpos          (vpos),
    .pause         (pause),
    .stage_done    (stage_done),
    .clear_overrun (clear_overrun),
`ifdef FRAME_DIV_EN
    .frame_div     (frame_div),
`endif
    .stage_req     (stage_req),
    .busy          (busy),
    .frame_tick    (frame_tick),
    .frame_cnt     (frame_cnt),
    .overrun       (overrun)
  );

  // One clock: outputs are stable #1 after the edge, then the beam advances like the sync generator.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (hpos == 10'd799) begin
      hpos = 10'd0;
      vpos = (vpos == 10'd524) ? 10'd0 : vpos + 10'd1;
    end else begin
      hpos = hpos + 10'd1;
    end
  endtask

  task automatic set_pos(input logic [9:0] v, input logic [9:0] h);
    vpos = v;
    hpos = h;
  endtask

  // Answer every request immediately until the sequence ends, within a cycle budget.
  task automatic finish_seq(input string name);
    for (int i = 0; i < 40 && busy; i++) begin
      stage_done = stage_req;
      cyc();
    end
    stage_done = '0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout: busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    total++;
    if ({stage_req, busy, frame_tick, frame_cnt, overrun} !== 23'd0) begin
      bad++;
      $display("FAIL reset_state: req=%b busy=%b tick=%b cnt=%h ovr=%b want all 0",
               stage_req, busy, frame_tick, frame_cnt, overrun);
    end
    reset = 1'b0;
    set_pos(10'd480, 10'd0);
    cyc();
    stage_done = 4'b0001; cyc();
    stage_done = 4'b0000; cyc();
    stage_done = 4'b0010; cyc();
    stage_done = 4'b0000; cyc();
    total++;
    if (stage_req !== 4'b0100) begin
      bad++;
      $display("FAIL reset_pre_idx2: req=%b want 0100", stage_req);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({stage_req, busy, frame_tick, frame_cnt, overrun} !== 23'd0) begin
      bad++;
      $display("FAIL reset_async_mid_run: req=%b busy=%b tick=%b cnt=%h ovr=%b want all 0",
               stage_req, busy, frame_tick, frame_cnt, overrun);
    end
    cyc();
    reset = 1'b0;
    exp_cnt = 16'd0;
    set_pos(10'd480, 10'd0);
    cyc();
    exp_cnt = exp_cnt + 16'd1;
    total++;
    if (stage_req !== 4'b0001 || frame_tick !== 1'b1 || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL reset_restart: req=%b tick=%b cnt=%h want 0001 1 %h",
               stage_req, frame_tick, frame_cnt, exp_cnt);
    end
    finish_seq("reset_restart");
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    logic [3:0] exp_req;
    set_pos(10'd480, 10'd0);
    cyc();
    exp_cnt = exp_cnt + 16'd1;
    total++;
    if (frame_tick !== 1'b1 || stage_req !== 4'b0001 || busy !== 1'b1 || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL full_start: tick=%b req=%b busy=%b cnt=%h want 1 0001 1 %h",
               frame_tick, stage_req, busy, frame_cnt, exp_cnt);
    end
    for (int s = 0; s < 4; s++) begin
      exp_req = 4'b0001 << s;
      cyc();
      if (s == 0) begin
        total++;
        if (frame_tick !== 1'b0) begin
          bad++;
          $display("FAIL full_tick_width: tick=%b want 0", frame_tick);
        end
      end
      cyc();
      total++;
      if (stage_req !== exp_req) begin
        bad++;
        $display("FAIL full_req_hold%0d: req=%b want %b", s, stage_req, exp_req);
      end
      stage_done = exp_req;
      cyc();
      stage_done = 4'b0000;
      total++;
      if (stage_req !== 4'b0000 || busy !== (s < 3)) begin
        bad++;
        $display("FAIL full_gap%0d: req=%b busy=%b want 0000 %b", s, stage_req, busy, (s < 3));
      end
      if (s < 3) begin
        cyc();
        total++;
        if (stage_req !== (exp_req << 1)) begin
          bad++;
          $display("FAIL full_next%0d: req=%b want %b", s, stage_req, exp_req << 1);
        end
      end
    end
    total++;
    if (frame_cnt !== exp_cnt || overrun !== 1'b0) begin
      bad++;
      $display("FAIL full_end: cnt=%h ovr=%b want %h 0", frame_cnt, overrun, exp_cnt);
    end
    $display("test_full_frame done");
  endtask

  task automatic test_abort();
    set_pos(10'd480, 10'd0);
    cyc();
    exp_cnt = exp_cnt + 16'd1;
    stage_done = 4'b0001; cyc();
    stage_done = 4'b0000; cyc();
    total++;
    if (stage_req !== 4'b0010) begin
      bad++;
      $display("FAIL abort_stage1: req=%b want 0010", stage_req);
    end
    set_pos(10'd524, 10'd798);
    cyc();
    total++;
    if (stage_req !== 4'b0010 || busy !== 1'b1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL abort_pre_end: req=%b busy=%b ovr=%b want 0010 1 0", stage_req, busy, overrun);
    end
    cyc();
    total++;
    if (stage_req !== 4'b0000 || busy !== 1'b0 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL abort_at_end: req=%b busy=%b ovr=%b want 0000 0 1", stage_req, busy, overrun);
    end
    cyc();
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL abort_sticky: ovr=%b want 1", overrun);
    end
    clear_overrun = 1'b1; cyc();
    clear_overrun = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL abort_clear: ovr=%b want 0", overrun);
    end
    set_pos(10'd480, 10'd0);
    cyc();
    exp_cnt = exp_cnt + 16'd1;
    set_pos(10'd524, 10'd799);
    clear_overrun = 1'b1;
    cyc();
    clear_overrun = 1'b0;
    total++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_set_wins: ovr=%b busy=%b want 1 0", overrun, busy);
    end
    clear_overrun = 1'b1; cyc();
    clear_overrun = 1'b0;
    $display("test_abort done");
  endtask

  task automatic test_completion_wins();
    set_pos(10'd480, 10'd0);
    cyc();
    exp_cnt = exp_cnt + 16'd1;
    stage_done = 4'b1110;
    cyc();
    cyc();
    total++;
    if (stage_req !== 4'b0001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ignore_other_done: req=%b busy=%b want 0001 1", stage_req, busy);
    end
    stage_done = 4'b0001; cyc();
    stage_done = 4'b0000; cyc();
    stage_done = 4'b0010; cyc();
    stage_done = 4'b0000; cyc();
    stage_done = 4'b0100; cyc();
    stage_done = 4'b0000; cyc();
    total++;
    if (stage_req !== 4'b1000) begin
      bad++;
      $display("FAIL completion_last_req: req=%b want 1000", stage_req);
    end
    set_pos(10'd524, 10'd799);
    stage_done = 4'b1000;
    cyc();
    stage_done = 4'b0000;
    total++;
    if (overrun !== 1'b0 || busy !== 1'b0 || stage_req !== 4'b0000) begin
      bad++;
      $display("FAIL completion_wins: ovr=%b busy=%b req=%b want 0 0 0000", overrun, busy, stage_req);
    end
    $display("test_completion_wins done");
  endtask

  task automatic test_pause();
    pause = 1'b1;
    set_pos(10'd480, 10'd0);
    cyc();
    total++;
    if (frame_tick !== 1'b0 || busy !== 1'b0 || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL pause_no_start: tick=%b busy=%b cnt=%h want 0 0 %h", frame_tick, busy, frame_cnt, exp_cnt);
    end
    cyc();
    pause = 1'b0;
    total++;
    if (busy !== 1'b0 || stage_req !== 4'b0000) begin
      bad++;
      $display("FAIL pause_idle: busy=%b req=%b want 0 0000", busy, stage_req);
    end
    $display("test_pause done");
  endtask

`ifdef FRAME_DIV_EN
  task automatic test_frame_div();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_cnt = 16'd0;
    frame_div = 2'd2;
    for (int f = 1; f <= 6; f++) begin
      set_pos(10'd480, 10'd0);
      cyc();
      total++;
      if (frame_tick !== ((f % 3) == 0)) begin
        bad++;
        $display("FAIL div_tick_frame%0d: tick=%b want %b", f, frame_tick, ((f % 3) == 0));
      end
      if (frame_tick) begin
        exp_cnt = exp_cnt + 16'd1;
        finish_seq("div");
      end
    end
    total++;
    if (frame_cnt !== 16'd2) begin
      bad++;
      $display("FAIL div_count: cnt=%h want 0002", frame_cnt);
    end
    frame_div = 2'd0;
    $display("test_frame_div done");
  endtask
`endif

  task automatic test_cnt_wrap();
    @(negedge clk);
    force dut.r_cnt = 16'hFFFF;
    #1;
    release dut.r_cnt;
    set_pos(10'd480, 10'd0);
    cyc();
    total++;
    if (frame_cnt !== 16'h0000 || frame_tick !== 1'b1) begin
      bad++;
      $display("FAIL cnt_wrap: cnt=%h tick=%b want 0000 1", frame_cnt, frame_tick);
    end
    finish_seq("cnt_wrap");
    $display("test_cnt_wrap done");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_abort();
    test_completion_wins();
    test_pause();
`ifdef FRAME_DIV_EN
    test_frame_div();
`endif
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
